// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and default widths.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer (word, address, valid) with fill / consume / flush.
// Only built when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module fetch_prefetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_fill_word,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic              i_consume,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_word,
    output logic [ADDR_W-1:0] o_addr
);
    logic              r_valid;
    logic [DATA_W-1:0] r_word;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
        end else if (i_flush || i_consume) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_fill) begin
            r_word <= i_fill_word;
            r_addr <= i_fill_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_addr  = r_addr;
endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/ack memory read, strobes the IR.
// Define FETCH_PREFETCH_EN to add a one-entry background prefetch buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_fetch_start,
    input  logic              i_jump_en,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_req,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_ir_data,
    output logic              o_ir_load,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_pc_out
);
    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd_req;
    logic              r_ir_load;
    logic [DATA_W-1:0] r_ir_data;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_req_done;

    assign w_target   = i_jump_en ? i_jump_addr : r_pc;
    assign w_addr_inc = r_mem_addr + ADDR_W'(1);

`ifdef FETCH_PREFETCH_EN
    // r_bg_req: background read outstanding while IDLE; r_stale: its ack must be dropped.
    logic              r_bg_req;
    logic              r_stale;
    logic              w_buf_valid;
    logic              w_buf_fill;
    logic              w_buf_consume;
    logic              w_buf_flush;
    logic              w_pf_hit;
    logic              w_bg_pending;
    logic [DATA_W-1:0] w_buf_word;
    logic [ADDR_W-1:0] w_buf_addr;
    logic [ADDR_W-1:0] w_buf_inc;

    assign w_pf_hit      = w_buf_valid && (w_buf_addr == r_pc) && !i_jump_en;
    assign w_bg_pending  = r_bg_req && !i_mem_ack;
    assign w_buf_fill    = (r_state == FETCH_IDLE) && r_bg_req && !r_stale && i_mem_ack
                           && !i_fetch_start && !i_jump_en;
    assign w_buf_consume = (r_state == FETCH_IDLE) && i_fetch_start && w_pf_hit;
    assign w_buf_flush   = (r_state == FETCH_IDLE) && i_jump_en;
    assign w_buf_inc     = w_buf_addr + ADDR_W'(1);
    assign w_req_done    = i_mem_ack && !r_stale;

    fetch_prefetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pf_buf (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_fill      (w_buf_fill),
        .i_fill_word (i_mem_rdata),
        .i_fill_addr (r_mem_addr),
        .i_consume   (w_buf_consume),
        .i_flush     (w_buf_flush),
        .o_valid     (w_buf_valid),
        .o_word      (w_buf_word),
        .o_addr      (w_buf_addr)
    );
`else
    assign w_req_done = i_mem_ack;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_mem_rd_req <= 1'b0;
            r_ir_load    <= 1'b0;
            r_ir_data    <= '0;
`ifdef FETCH_PREFETCH_EN
            r_bg_req     <= 1'b0;
            r_stale      <= 1'b0;
`endif
        end else begin
            r_ir_load <= 1'b0;
            case (r_state)
                FETCH_IDLE: begin
`ifdef FETCH_PREFETCH_EN
                    if (i_fetch_start) begin
                        if (w_pf_hit) begin
                            r_ir_data <= w_buf_word;
                            r_pc      <= w_buf_inc;
                            r_ir_load <= 1'b1;
                            r_state   <= FETCH_LOAD;
                        end else if (r_bg_req && !r_stale && !i_jump_en && i_mem_ack) begin
                            r_ir_data    <= i_mem_rdata;
                            r_pc         <= w_addr_inc;
                            r_mem_rd_req <= 1'b0;
                            r_bg_req     <= 1'b0;
                            r_ir_load    <= 1'b1;
                            r_state      <= FETCH_LOAD;
                        end else begin
                            r_state      <= FETCH_REQ;
                            r_mem_rd_req <= 1'b1;
                            r_bg_req     <= 1'b0;
                            r_pc         <= w_target;
                            // A still-open read to the wrong address must complete before reissue.
                            if (w_bg_pending && (i_jump_en || r_stale)) begin
                                r_stale <= 1'b1;
                            end else begin
                                r_stale <= 1'b0;
                                if (!w_bg_pending) r_mem_addr <= w_target;
                            end
                        end
                    end else begin
                        r_pc <= w_target;
                        if (r_bg_req && i_mem_ack) begin
                            r_bg_req     <= 1'b0;
                            r_mem_rd_req <= 1'b0;
                            r_stale      <= 1'b0;
                        end else if (i_jump_en && r_bg_req) begin
                            r_stale <= 1'b1;
                        end
                    end
`else
                    r_pc <= w_target;
                    if (i_fetch_start) begin
                        r_state      <= FETCH_REQ;
                        r_mem_rd_req <= 1'b1;
                        r_mem_addr   <= w_target;
                    end
`endif
                end
                FETCH_REQ: begin
                    if (w_req_done) begin
                        r_ir_data    <= i_mem_rdata;
                        r_pc         <= w_addr_inc;
                        r_mem_rd_req <= 1'b0;
                        r_ir_load    <= 1'b1;
                        r_state      <= FETCH_LOAD;
                    end
`ifdef FETCH_PREFETCH_EN
                    if (i_mem_ack && r_stale) begin
                        r_stale    <= 1'b0;
                        r_mem_addr <= r_pc;
                    end
`endif
                end
                FETCH_LOAD: begin
                    r_state <= FETCH_IDLE;
`ifdef FETCH_PREFETCH_EN
                    r_mem_rd_req <= 1'b1;
                    r_bg_req     <= 1'b1;
                    r_stale      <= 1'b0;
                    r_mem_addr   <= r_pc;
`endif
                end
                default: r_state <= FETCH_IDLE;
            endcase
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rd_req = r_mem_rd_req;
    assign o_ir_data    = r_ir_data;
    assign o_ir_load    = r_ir_load;
    assign o_busy       = (r_state != FETCH_IDLE);
    assign o_pc_out     = r_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder with programmable wait states,
// expected IR loads queued at fetch time and popped on each ir_load strobe.
module tb_fetch_unit;
    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_fetch_start = 1'b0;
    logic        i_jump_en = 1'b0;
    logic [15:0] i_jump_addr = 16'h0;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_rdata = 16'h0;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd_req;
    logic [15:0] o_ir_data;
    logic        o_ir_load;
    logic        o_busy;
    logic [15:0] o_pc_out;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_loads = 0;
    int          w_cycles = 0;
    int          resp_cnt = 0;
    bit          resp_en = 1'b1;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = 16'h0;
    logic [15:0] hold_addr = 16'h0;
    int          loads0;

    fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (i_reset_n),
        .i_fetch_start (i_fetch_start),
        .i_jump_en     (i_jump_en),
        .i_jump_addr   (i_jump_addr),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd_req  (o_mem_rd_req),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_ir_data     (o_ir_data),
        .o_ir_load     (o_ir_load),
        .o_busy        (o_busy),
        .o_pc_out      (o_pc_out)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: acks after w_cycles wait states and checks the address holds meanwhile.
    initial begin
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                i_mem_ack   = man_ack;
                i_mem_rdata = man_data;
                resp_cnt    = 0;
            end else if (o_mem_rd_req) begin
                if (resp_cnt == 0) hold_addr = o_mem_addr;
                else check("mem_addr_stable", o_mem_addr, hold_addr);
                if (resp_cnt >= w_cycles) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem_word(o_mem_addr);
                    resp_cnt    = 0;
                end else begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = 16'hXXXX;
                    resp_cnt++;
                end
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = 16'h0;
                resp_cnt    = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_ir_load) begin
                n_loads++;
                if (sb.size() == 0) begin
                    check("ir_load_unexpected", {31'd0, o_ir_load}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ir_data", {16'd0, o_ir_data}, {16'd0, mon_e.word});
                    check("pc_after_fetch", {16'd0, o_pc_out}, {16'd0, mon_e.pc});
                    if (mon_e.cyc >= 0) check("ir_load_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!o_busy && sb.size() == 0) break;
        end
        if (n >= 100) check("idle_timeout", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_fetch(input logic jmp, input logic [15:0] jaddr, input logic [15:0] faddr,
                            input int lat, input bit chk_req);
        exp_t e;
        @(negedge clk);
        e.word = mem_word(faddr);
        e.pc   = faddr + 16'd1;
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
        i_fetch_start = 1'b1;
        i_jump_en     = jmp;
        i_jump_addr   = jaddr;
        @(negedge clk);
        i_fetch_start = 1'b0;
        i_jump_en     = 1'b0;
        if (chk_req) begin
            check("req_after_start", {31'd0, o_mem_rd_req}, 32'd1);
            check("mem_addr", {16'd0, o_mem_addr}, {16'd0, faddr});
            check("busy_in_req", {31'd0, o_busy}, 32'd1);
        end
    endtask

    task automatic do_jump(input logic [15:0] jaddr);
        @(negedge clk);
        i_jump_en   = 1'b1;
        i_jump_addr = jaddr;
        @(negedge clk);
        i_jump_en   = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_req", {31'd0, o_mem_rd_req}, 32'd0);
        check("rst_ir_load", {31'd0, o_ir_load}, 32'd0);
        check("rst_ir_data", {16'd0, o_ir_data}, 32'd0);
        check("rst_pc", {16'd0, o_pc_out}, {16'd0, RST_PC});
        check("rst_mem_addr", {16'd0, o_mem_addr}, {16'd0, RST_PC});
        i_reset_n = 1'b1;

        // Zero wait states: ir_load two cycles after fetch_start.
        w_cycles = 0;
        do_fetch(1'b0, 16'h0, 16'h0000, 2, 1'b1);
        wait_idle();
        settle(12);
        check("ir_data_hold", {16'd0, o_ir_data}, 32'h0000A5C3);

        // Three wait states.
        w_cycles = 3;
        do_fetch(1'b0, 16'h0, 16'h0001, PF ? 1 : 5, !PF);
        wait_idle();
        settle(12);

        // Jump and fetch together.
        w_cycles = 1;
        do_fetch(1'b1, 16'h0100, 16'h0100, 3, 1'b1);
        wait_idle();
        settle(12);
        do_jump(16'h0200);
        check("pc_jump_only", {16'd0, o_pc_out}, 32'h00000200);
        check("busy_jump_only", {31'd0, o_busy}, 32'd0);
        settle(4);

        // PC wrap and commands ignored while busy.
        w_cycles = 2;
        do_fetch(1'b1, 16'hFFFF, 16'hFFFF, 4, 1'b1);
        i_fetch_start = 1'b1;
        i_jump_en     = 1'b1;
        i_jump_addr   = 16'h1234;
        @(negedge clk);
        i_fetch_start = 1'b0;
        i_jump_en     = 1'b0;
        wait_idle();
        settle(12);
        check("pc_wrap", {16'd0, o_pc_out}, 32'h00000000);

        // Reset in the middle of a request; late ack must be ignored.
        do_jump(16'h0300);
        check("pc_jump_0300", {16'd0, o_pc_out}, 32'h00000300);
        resp_en = 1'b0;
        man_ack = 1'b0;
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(negedge clk);
        i_fetch_start = 1'b0;
        check("t5_req", {31'd0, o_mem_rd_req}, 32'd1);
        check("t5_mem_addr", {16'd0, o_mem_addr}, 32'h00000300);
        @(negedge clk);
        check("t5_busy", {31'd0, o_busy}, 32'd1);
        i_reset_n = 1'b0;
        @(negedge clk);
        check("t5_rst_req", {31'd0, o_mem_rd_req}, 32'd0);
        check("t5_rst_pc", {16'd0, o_pc_out}, {16'd0, RST_PC});
        check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t5_rst_ir_data", {16'd0, o_ir_data}, 32'd0);
        check("t5_rst_mem_addr", {16'd0, o_mem_addr}, {16'd0, RST_PC});
        i_reset_n = 1'b1;
        loads0    = n_loads;
        man_ack   = 1'b1;
        man_data  = 16'hDEAD;
        repeat (2) @(negedge clk);
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_load", n_loads, loads0);
        check("t5_pc_kept", {16'd0, o_pc_out}, {16'd0, RST_PC});
        check("t5_ir_data_kept", {16'd0, o_ir_data}, 32'd0);
        resp_en = 1'b1;
        settle(2);

`ifdef FETCH_PREFETCH_EN
        // Prefetch hit, stale background word after a jump, fetch during background read.
        w_cycles = 1;
        do_fetch(1'b1, 16'h0400, 16'h0400, 3, 1'b1);
        wait_idle();
        settle(12);
        w_cycles = 4;
        do_fetch(1'b0, 16'h0, 16'h0401, 1, 1'b0);
        wait_idle();
        do_jump(16'h0500);
        check("pf_pc_jump", {16'd0, o_pc_out}, 32'h00000500);
        settle(12);
        do_fetch(1'b0, 16'h0, 16'h0500, 6, 1'b1);
        wait_idle();
        do_fetch(1'b0, 16'h0, 16'h0501, -1, 1'b0);
        wait_idle();
        settle(12);
        check("pf_pc_final", {16'd0, o_pc_out}, 32'h00000502);
`endif

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
